// File: rtl/tnoc_port_arbiter.sv
// Round-robin output-port arbiter: grants one requester at a time and holds
// the grant until that requester signals release on its tail flit.
//
// state  | meaning
// IDLE   | no grant held; arbitrate among enabled requests from pointer P
// LOCKED | one grant held; waiting for i_free from the granted requester
module tnoc_port_arbiter #(
    parameter int                    REQUESTERS      = 5,
    parameter logic [REQUESTERS-1:0] AVAILABLE_PORTS = {REQUESTERS{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQUESTERS-1:0] i_request,
    input  logic [REQUESTERS-1:0] i_free,
    output logic [REQUESTERS-1:0] o_grant,
    output logic                  o_busy,
    output logic [2:0]            o_grant_index
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [2:0] LAST_IDX  = 3'(REQUESTERS - 1);
    localparam logic [REQUESTERS-1:0] ONE_HOT_0 = {{(REQUESTERS-1){1'b0}}, 1'b1};

    logic [0:0]            state_q, state_d;
    logic [REQUESTERS-1:0] grant_q, grant_d;
    logic [2:0]            index_q, index_d;
    logic [2:0]            ptr_q, ptr_d;
    logic                  busy_q, busy_d;

    logic [REQUESTERS-1:0]   eff_req;
    logic [2*REQUESTERS-1:0] req_dbl;
    logic [2*REQUESTERS-1:0] req_rot_full;
    logic [REQUESTERS-1:0]   req_rot;
    logic [REQUESTERS-1:0]   probe;
    logic                    found;
    logic [2:0]              win_idx;
    int                      sum;
    logic                    release_hit;
    logic [2:0]              ptr_after_release;

    assign eff_req = i_request & AVAILABLE_PORTS;

    // Rotating the doubled vector puts requester P at bit 0, so the first set
    // bit found is the round-robin winner.
    assign req_dbl      = {eff_req, eff_req};
    assign req_rot_full = req_dbl >> ptr_q;
    assign req_rot      = req_rot_full[REQUESTERS-1:0];

    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        sum     = 0;
        probe   = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            probe = req_rot >> k;
            if (!found && probe[0]) begin
                found = 1'b1;
                sum   = int'(ptr_q) + k;
                if (sum >= REQUESTERS) begin
                    sum = sum - REQUESTERS;
                end
                win_idx = 3'(sum);
            end
        end
    end

    assign release_hit       = (state_q == ST_LOCKED) && |(i_free & grant_q);
    assign ptr_after_release = (index_q == LAST_IDX) ? 3'd0 : index_q + 3'd1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        index_d = index_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_LOCKED;
                    grant_d = ONE_HOT_0 << win_idx;
                    index_d = win_idx;
                    busy_d  = 1'b1;
                end
            end
            ST_LOCKED: begin
                // Release wins over any same-cycle request; the freed
                // requester competes again only from the following IDLE cycle.
                if (release_hit) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    index_d = 3'd0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_after_release;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                index_d = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            index_q <= 3'd0;
            ptr_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_busy        = busy_q;
    assign o_grant_index = index_q;

endmodule

// File: tb/tb_tnoc_port_arbiter.sv
// Bench for tnoc_port_arbiter: a full-mask and a reduced-mask instance share
// stimulus and are both compared every cycle against a per-instance model.
module tb_tnoc_port_arbiter;

    localparam int R = 5;

    logic         clk;
    logic         rst_n;
    logic [R-1:0] req;
    logic [R-1:0] free;

    logic [R-1:0] grant_a, grant_b;
    logic         busy_a, busy_b;
    logic [2:0]   idx_a, idx_b;

    int tests;
    int fails;

    logic [R-1:0] m_mask   [2];
    logic         m_locked [2];
    int           m_g      [2];
    int           m_p      [2];

    tnoc_port_arbiter #(.REQUESTERS(R), .AVAILABLE_PORTS(5'b11111)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_request(req), .i_free(free),
        .o_grant(grant_a), .o_busy(busy_a), .o_grant_index(idx_a)
    );

    tnoc_port_arbiter #(.REQUESTERS(R), .AVAILABLE_PORTS(5'b01111)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_request(req), .i_free(free),
        .o_grant(grant_b), .o_busy(busy_b), .o_grant_index(idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_locked[u] = 1'b0;
            m_g[u]      = 0;
            m_p[u]      = 0;
        end
    endtask

    // Spec-level behaviour: hold until the owner frees, then search upward from P.
    task automatic model_edge();
        int idx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int u = 0; u < 2; u++) begin
            if (m_locked[u]) begin
                if (free[m_g[u]]) begin
                    m_locked[u] = 1'b0;
                    m_p[u]      = (m_g[u] + 1) % R;
                end
            end else begin
                for (int k = 0; k < R; k++) begin
                    idx = (m_p[u] + k) % R;
                    if (!m_locked[u] && req[idx] && m_mask[u][idx]) begin
                        m_locked[u] = 1'b1;
                        m_g[u]      = idx;
                    end
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_grant(input int u);
        logic [7:0] one;
        one = 8'd1;
        return m_locked[u] ? (one << m_g[u]) : 8'd0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_grant_a"}, 8'(grant_a), exp_grant(0));
        chk({tag, "_busy_a"},  8'(busy_a),  8'(m_locked[0]));
        chk({tag, "_index_a"}, 8'(idx_a),   m_locked[0] ? 8'(m_g[0]) : 8'd0);
        chk({tag, "_grant_b"}, 8'(grant_b), exp_grant(1));
        chk({tag, "_busy_b"},  8'(busy_b),  8'(m_locked[1]));
        chk({tag, "_index_b"}, 8'(idx_b),   m_locked[1] ? 8'(m_g[1]) : 8'd0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    logic [R-1:0] noise;

    initial begin
        tests = 0;
        fails = 0;
        m_mask[0] = 5'b11111;
        m_mask[1] = 5'b01111;
        model_reset();
        rst_n = 1'b0;
        req   = '0;
        free  = '0;

        // Reset state
        tick("rst");
        tick("rst");
        chk("rst_grant", 8'(grant_a), 8'h00);
        chk("rst_busy",  8'(busy_a),  8'h00);
        chk("rst_index", 8'(idx_a),   8'h00);
        rst_n = 1'b1;
        tick("idle");
        chk("idle_grant", 8'(grant_a), 8'h00);

        // First grant from P=0 lands on requester 2
        req = 5'b10100;
        tick("g2");
        chk("g2_grant", 8'(grant_a), 8'h04);
        chk("g2_index", 8'(idx_a),   8'd2);
        chk("g2_busy",  8'(busy_a),  8'd1);

        // Release 2 with 0,2,4 requesting: idle, then 4, then 0
        req  = 5'b10101;
        free = 5'b00100;
        tick("rel2");
        chk("rel2_grant", 8'(grant_a), 8'h00);
        free = '0;
        tick("g4");
        chk("g4_grant", 8'(grant_a), 8'h10);
        free = 5'b10000;
        tick("rel4");
        chk("rel4_grant", 8'(grant_a), 8'h00);
        free = '0;
        tick("g0");
        chk("g0_grant", 8'(grant_a), 8'h01);

        // Holder drops its request and a foreign free arrives: grant holds
        req  = 5'b10100;
        free = 5'b01000;
        tick("hold0");
        chk("hold0_grant", 8'(grant_a), 8'h01);
        free = '0;
        for (int i = 0; i < 3; i++) tick("hold0b");
        chk("hold0b_grant", 8'(grant_a), 8'h01);
        free = 5'b00001;
        tick("rel0");
        chk("rel0_grant", 8'(grant_a), 8'h00);
        free = '0;
        tick("g2b");
        chk("g2b_grant", 8'(grant_a), 8'h04);
        req  = '0;
        free = 5'b00100;
        tick("rel2b");
        free = '0;

        // Masked requester 4 on instance B is never granted
        req = 5'b10000;
        for (int i = 0; i < 10; i++) begin
            tick("mask");
            chk("mask_grant_b", 8'(grant_b), 8'h00);
            chk("mask_busy_b",  8'(busy_b),  8'h00);
        end
        req  = '0;
        free = 5'b10000;
        tick("mask_rel");
        free = '0;

        // Full rotation with one idle cycle between grants
        rst_n = 1'b0;
        tick("rr_rst");
        rst_n = 1'b1;
        req   = 5'b11111;
        for (int n = 0; n < 6; n++) begin
            tick("rr_g");
            chk("rr_order", 8'(idx_a), 8'(n % R));
            chk("rr_busy",  8'(busy_a), 8'd1);
            free = grant_a;
            tick("rr_rel");
            chk("rr_idle", 8'(grant_a), 8'h00);
            free = '0;
        end
        req = '0;
        tick("rr_end");

        // Async reset while locked on 3
        rst_n = 1'b0;
        tick("ar_rst");
        rst_n = 1'b1;
        req   = 5'b01000;
        tick("ar_g3");
        chk("ar_g3_grant", 8'(grant_a), 8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_async_grant", 8'(grant_a), 8'h00);
        chk("ar_async_busy",  8'(busy_a),  8'h00);
        chk("ar_async_index", 8'(idx_a),   8'h00);
        tick("ar_hold");
        rst_n = 1'b1;
        req   = 5'b11111;
        tick("ar_g0");
        chk("ar_g0_index", 8'(idx_a), 8'd0);

        // Randomized traffic, noisy frees and occasional resets
        for (int i = 0; i < 600; i++) begin
            req   = R'($urandom);
            noise = R'($urandom) & R'($urandom);
            free  = ($urandom_range(0, 2) == 0) ? (grant_a | grant_b | noise) : noise;
            rst_n = ($urandom_range(0, 99) != 0);
            tick("rand");
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
